// File: rtl/tetris_move_ctrl.sv
// tetris_move_ctrl: button/gravity command generator for the falling block.
// Emits one-cycle drop/left/right pulses (one per two cycles) and landed.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   btn_left/right/down    raw asynchronous buttons
//   pause                  freezes motion, clears pending requests
//   block_pos_x/y          current block position (boundary checks)
//   drop/left/right        one-cycle move pulses, mutually exclusive
//   landed                 gravity fired with the block on the bottom row
module tetris_move_ctrl #(
    parameter int GRAV_TICKS = 25_000_000,
    parameter int SOFT_TICKS = 2_500_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int REP_DELAY  = 10_000_000,
    parameter int REP_RATE   = 2_500_000,
    parameter int FIELD_W    = 10,
    parameter int FIELD_H    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       pause,
    input  logic [4:0] block_pos_x,
    input  logic [4:0] block_pos_y,
    output logic       drop,
    output logic       left,
    output logic       right,
    output logic       landed
);

    localparam int GMAX = (GRAV_TICKS > SOFT_TICKS) ? GRAV_TICKS : SOFT_TICKS;
    localparam int RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int GW = (GMAX > 1) ? $clog2(GMAX) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [GW-1:0] G_LAST  = GW'(GRAV_TICKS - 1);
    localparam logic [GW-1:0] S_LAST  = GW'(SOFT_TICKS - 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REP_RATE - 1);
    localparam logic [4:0]    X_LAST  = 5'(FIELD_W - 1);
    localparam logic [4:0]    Y_LAST  = 5'(FIELD_H - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } hstate_t;

    // Bit order for button vectors: [0]=left, [1]=right, [2]=down
    logic [2:0]         btn_raw;
    logic [2:0]         sync1;
    logic [2:0]         sync2;
    logic [2:0]         deb;
    logic [1:0]         deb_q;
    logic [2:0][DW-1:0] deb_cnt;

    assign btn_raw = {btn_down, btn_right, btn_left};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_q   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb[1:0];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (deb_cnt[i] == D_LAST) begin
                        deb[i]     <= ~deb[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Horizontal auto-repeat, index 0 = left, 1 = right
    hstate_t            st   [2];
    hstate_t            st_n [2];
    logic [1:0][RW-1:0] rcnt;
    logic [1:0][RW-1:0] rcnt_n;
    logic [1:0]         hset;
    logic               both;

    assign both = deb[0] & deb[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st[0] <= IDLE;
            st[1] <= IDLE;
            rcnt  <= '0;
        end else begin
            st[0] <= st_n[0];
            st[1] <= st_n[1];
            rcnt  <= rcnt_n;
        end
    end

    always_comb begin
        st_n[0] = st[0];
        st_n[1] = st[1];
        rcnt_n  = rcnt;
        hset    = '0;
        for (int d = 0; d < 2; d++) begin
            if (both || !deb[d]) begin
                st_n[d]   = IDLE;
                rcnt_n[d] = '0;
            end else begin
                unique case (st[d])
                    IDLE: begin
                        // Only a fresh press arms; a button still held
                        // after a two-button conflict stays idle.
                        if (!deb_q[d]) begin
                            st_n[d]   = DELAY;
                            rcnt_n[d] = '0;
                            hset[d]   = 1'b1;
                        end
                    end
                    DELAY: begin
                        if (!pause) begin
                            if (rcnt[d] == RD_LAST) begin
                                st_n[d]   = REPEAT;
                                rcnt_n[d] = '0;
                                hset[d]   = 1'b1;
                            end else begin
                                rcnt_n[d] = rcnt[d] + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!pause) begin
                            if (rcnt[d] == RR_LAST) begin
                                rcnt_n[d] = '0;
                                hset[d]   = 1'b1;
                            end else begin
                                rcnt_n[d] = rcnt[d] + 1'b1;
                            end
                        end
                    end
                    default: st_n[d] = IDLE;
                endcase
            end
        end
    end

    // Gravity; >= makes a shortened period wrap at once
    logic [GW-1:0] gcnt;
    logic [GW-1:0] g_last;
    logic          wrap;

    assign g_last = deb[2] ? S_LAST : G_LAST;
    assign wrap   = !pause && (gcnt >= g_last);

    // Arbitration: drop > left > right, with a gap cycle after a move
    logic pend_d;
    logic pend_l;
    logic pend_r;
    logic gap;
    logic can;
    logic gnt_d;
    logic gnt_l;
    logic gnt_r;
    logic land;

    assign gap   = drop | left | right;
    assign can   = !gap && !pause;
    assign gnt_d = can && pend_d;
    assign gnt_l = can && !pend_d && pend_l;
    assign gnt_r = can && !pend_d && !pend_l && pend_r;
    assign land  = gnt_d && (block_pos_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt <= '0;
        end else if (pause) begin
            gcnt <= gcnt;
        end else if (land || wrap) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_d <= 1'b0;
            pend_l <= 1'b0;
            pend_r <= 1'b0;
            drop   <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            landed <= 1'b0;
        end else if (pause) begin
            pend_d <= 1'b0;
            pend_l <= 1'b0;
            pend_r <= 1'b0;
            drop   <= 1'b0;
            left   <= 1'b0;
            right  <= 1'b0;
            landed <= 1'b0;
        end else begin
            // A new request in the consume cycle keeps the bit set
            pend_d <= wrap | (pend_d & ~gnt_d);
            if (both) begin
                pend_l <= 1'b0;
                pend_r <= 1'b0;
            end else begin
                pend_l <= hset[0] | (pend_l & ~gnt_l);
                pend_r <= hset[1] | (pend_r & ~gnt_r);
            end
            drop   <= gnt_d && !land;
            landed <= land;
            left   <= gnt_l && (block_pos_x != 5'd0);
            right  <= gnt_r && (block_pos_x != X_LAST);
        end
    end

endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Scoreboard bench for tetris_move_ctrl: stimulus queues expected pulses
// with their cycle numbers, a negedge monitor pops and compares them.
module tb_tetris_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_down = 1'b0;
    logic       pause = 1'b0;
    logic [4:0] pos_x = 5'd5;
    logic [4:0] pos_y = 5'd0;
    logic       drop;
    logic       left;
    logic       right;
    logic       landed;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int R = 0;

    // Output code = {landed, drop, left, right}
    localparam logic [3:0] RT = 4'b0001;
    localparam logic [3:0] LT = 4'b0010;
    localparam logic [3:0] DR = 4'b0100;
    localparam logic [3:0] LD = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] o;
    } exp_t;

    exp_t q[$];

    tetris_move_ctrl #(
        .GRAV_TICKS(8),
        .SOFT_TICKS(2),
        .DEB_CYCLES(3),
        .REP_DELAY(6),
        .REP_RATE(4),
        .FIELD_W(10),
        .FIELD_H(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .btn_down(btn_down),
        .pause(pause),
        .block_pos_x(pos_x),
        .block_pos_y(pos_y),
        .drop(drop),
        .left(left),
        .right(right),
        .landed(landed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    exp_t       me;
    logic [3:0] mo;

    always @(negedge clk) begin
        mo = {landed, drop, left, right};
        if (rst_n) begin
            if (mo != 4'b0) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: got %b at rel %0d, expected none",
                             mo, cyc - R);
                end else begin
                    me = q.pop_front();
                    if (me.cyc != cyc || me.o != mo) begin
                        errors++;
                        $display("FAIL pulse: got %b at rel %0d, expected %b at rel %0d",
                                 mo, cyc - R, me.o, me.cyc - R);
                    end
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                checks++;
                errors++;
                me = q.pop_front();
                $display("FAIL missing: got none at rel %0d, expected %b",
                         cyc - R, me.o);
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] act,
                       input logic [3:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp_v);
        end
    endtask

    task automatic ev(input int rel, input logic [3:0] o);
        q.push_back('{R + rel, o});
    endtask

    task automatic wait_rel(input int rel);
        while (cyc < R + rel) @(negedge clk);
    endtask

    task automatic chk_empty(input string nm);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses left, expected 0",
                     nm, q.size());
        end
        q.delete();
    endtask

    task automatic end_scn(input int rel, input string nm);
        wait_rel(rel);
        chk_empty(nm);
    endtask

    task automatic reset_dut(input logic [4:0] x, input logic [4:0] y);
        rst_n = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        btn_down = 1'b0;
        pause = 1'b0;
        #1;
        chk("reset_outputs", {landed, drop, left, right}, 4'b0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        pos_x = x;
        pos_y = y;
        rst_n = 1'b1;
        R = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // Gravity every 8, then landing on the bottom row
        reset_dut(5'd5, 5'd0);
        ev(9, DR); ev(17, DR); ev(25, DR); ev(33, DR);
        ev(41, LD); ev(50, LD);
        wait_rel(34);
        pos_y = 5'd19;
        end_scn(52, "gravity_landed");

        // Left press latency, delay, repeat; placed to avoid gravity
        reset_dut(5'd5, 5'd0);
        ev(9, DR); ev(13, LT); ev(17, DR); ev(19, LT);
        ev(23, LT); ev(25, DR); ev(27, LT); ev(31, LT);
        ev(33, DR); ev(41, DR);
        wait_rel(6);
        btn_left = 1'b1;
        wait_rel(27);
        btn_left = 1'b0;
        end_scn(44, "left_repeat");

        // Two-cycle glitch, then left held at x=0
        reset_dut(5'd5, 5'd0);
        ev(9, DR); ev(17, DR); ev(25, DR); ev(33, DR);
        wait_rel(2);
        btn_left = 1'b1;
        wait_rel(4);
        btn_left = 1'b0;
        wait_rel(18);
        pos_x = 5'd0;
        wait_rel(19);
        btn_left = 1'b1;
        end_scn(40, "glitch_left_edge");

        // Right held at x=9, then both held, then x moved inward
        reset_dut(5'd9, 5'd0);
        btn_right = 1'b1;
        ev(9, DR); ev(17, DR); ev(25, DR); ev(33, DR); ev(41, DR);
        wait_rel(19);
        btn_left = 1'b1;
        wait_rel(27);
        pos_x = 5'd5;
        end_scn(44, "right_edge_both");

        // Left request and gravity wrap on the same edge
        reset_dut(5'd5, 5'd0);
        ev(9, DR); ev(11, LT); ev(15, LT); ev(17, DR);
        ev(19, LT); ev(23, LT); ev(25, DR); ev(27, LT);
        ev(33, DR);
        wait_rel(2);
        btn_left = 1'b1;
        wait_rel(23);
        btn_left = 1'b0;
        end_scn(36, "collision");

        // Soft drop, then a 20-cycle pause holding the count
        reset_dut(5'd5, 5'd0);
        btn_down = 1'b1;
        ev(7, DR); ev(9, DR); ev(11, DR); ev(13, DR);
        ev(35, DR); ev(37, DR); ev(39, DR); ev(41, DR);
        wait_rel(13);
        pause = 1'b1;
        wait_rel(33);
        pause = 1'b0;
        end_scn(42, "soft_pause");

        // Async reset while left is repeating
        reset_dut(5'd5, 5'd0);
        ev(9, DR); ev(13, LT); ev(17, DR); ev(19, LT);
        wait_rel(6);
        btn_left = 1'b1;
        wait_rel(22);
        @(posedge clk);
        #1;
        chk("left_before_reset", {landed, drop, left, right}, LT);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {landed, drop, left, right}, 4'b0);
        chk_empty("pre_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        R = cyc;
        ev(7, LT); ev(9, DR); ev(13, LT);
        end_scn(14, "after_async_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
